// File: rtl/receive_info_ctrl.sv
// receive_info_ctrl: framing sequencer for the 137-bit receive_info serial shifter.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit after each frame.
module receive_info_ctrl #(
  parameter int unsigned KEY_BITS    = 128,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned FRAME_BITS  = KEY_BITS + ADDR_BITS + 1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  frame_start,
  input  logic                  bit_strobe,
  input  logic                  serial_in,
  input  logic [FRAME_BITS-1:0] parallel_in,
  output logic                  shift_enable,
  output logic [KEY_BITS-1:0]   key,
  output logic [ADDR_BITS-1:0]  address,
  output logic                  mode,
  output logic                  info_valid,
  input  logic                  info_ready,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    HOLD
`ifdef PARITY_CHECK_EN
    , PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 err_d;
  logic                 load_c;
  logic [KEY_BITS-1:0]  key_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 mode_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 err_q;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;
`else
  logic unused_serial;
  assign unused_serial = serial_in;
`endif

  // Restart beats a same-cycle strobe, so the strobe must not reach the shifter.
  assign shift_enable = (state_q == SHIFT) && bit_strobe && !frame_start;

  // Next-state, counters and error/load strobes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    err_d     = 1'b0;
    load_c    = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
`ifdef PARITY_CHECK_EN
          par_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (frame_start) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
`ifdef PARITY_CHECK_EN
          par_d     = 1'b0;
`endif
        end else if (bit_strobe) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          gap_cnt_d = '0;
`ifdef PARITY_CHECK_EN
          par_d     = par_q ^ serial_in;
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = PARITY;
`else
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = LOAD;
`endif
        end else if (gap_cnt_q == GAP_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (frame_start) begin
          err_d     = 1'b1;
          state_d   = SHIFT;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          par_d     = 1'b0;
        end else if (bit_strobe) begin
          // Even parity: data XOR parity bit must be zero.
          if (par_q ^ serial_in) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else if (gap_cnt_q == GAP_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
`endif
      LOAD: begin
        load_c  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (info_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, captured fields and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      key_q     <= '0;
      addr_q    <= '0;
      mode_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= (state_d == HOLD);
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
`endif
      if (load_c) begin
        key_q  <= parallel_in[FRAME_BITS-1:ADDR_BITS+1];
        addr_q <= parallel_in[ADDR_BITS:1];
        mode_q <= parallel_in[0];
      end
    end
  end

  assign key        = key_q;
  assign address    = addr_q;
  assign mode       = mode_q;
  assign info_valid = valid_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_receive_info_ctrl.sv
// tb_receive_info_ctrl: vector table, directed frame scenarios and random frames
// for receive_info_ctrl; a behavioural stand-in models the receive_info shifter.
module tb_receive_info_ctrl;

  localparam int unsigned TIMEOUT_CYC = 255;

  typedef struct packed {
    logic [127:0] key;
    logic [7:0]   addr;
    logic         mode;
  } frame_t;

  typedef struct {
    logic fs;
    logic bs;
    logic si;
    logic rdy;
    logic se;
    logic busy;
    logic err;
    logic valid;
  } vec_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         frame_start, bit_strobe, serial_in, info_ready;
  logic [136:0] parallel_in;
  logic         shift_enable, mode, info_valid, busy, frame_err;
  logic [127:0] key;
  logic [7:0]   address;

  int   n_vec = 0;
  int   n_err = 0;
  int   se_cnt, err_cnt, valid_cnt;
  logic s_se, s_busy, s_err, s_valid;

  always #5 clk = ~clk;

  receive_info_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .frame_start (frame_start),
    .bit_strobe  (bit_strobe),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .shift_enable(shift_enable),
    .key         (key),
    .address     (address),
    .mode        (mode),
    .info_valid  (info_valid),
    .info_ready  (info_ready),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  // Stand-in for receive_info: MSB-first serial-to-parallel shifter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) parallel_in <= '0;
    else if (shift_enable) parallel_in <= {parallel_in[135:0], serial_in};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, sample outputs on the falling edge.
  task automatic cyc(input logic f, input logic b, input logic s);
    frame_start = f;
    bit_strobe  = b;
    serial_in   = s;
    @(negedge clk);
    s_se    = shift_enable;
    s_busy  = busy;
    s_err   = frame_err;
    s_valid = info_valid;
    if (s_se)    se_cnt++;
    if (s_err)   err_cnt++;
    if (s_valid) valid_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic start();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  // Sends frame_start, then all bits MSB first with random gaps up to maxgap;
  // long_gap_at inserts the longest legal gap before that bit index.
  task automatic run_frame(input frame_t fr, input int maxgap, input logic flip,
                           input int long_gap_at);
    logic [136:0] bits;
    bits      = fr;
    se_cnt    = 0;
    err_cnt   = 0;
    valid_cnt = 0;
    start();
    for (int i = 136; i >= 0; i--) begin
      int g;
      g = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
      if (i == long_gap_at) g = TIMEOUT_CYC - 1;
      repeat (g) idle();
      strobe(bits[i]);
    end
`ifdef PARITY_CHECK_EN
    strobe((^bits) ^ flip);
`else
    if (flip) idle();
`endif
  endtask

  // Waits for info_valid, holds ready low for d valid cycles, then accepts.
  task automatic collect(input frame_t fr, input int d, input string tag);
    int lat;
    lat = 0;
    do begin
      info_ready = (d == 0);
      idle();
      lat++;
    end while (!s_valid && lat < 8);
    chk({tag, "_latency"}, 137'(lat), 137'(2));
    chk({tag, "_key"}, 137'(key), 137'(fr.key));
    chk({tag, "_addr"}, 137'(address), 137'(fr.addr));
    chk({tag, "_mode"}, 137'(mode), 137'(fr.mode));
    for (int j = 1; j <= d; j++) begin
      info_ready = (j == d);
      idle();
      chk({tag, "_hold_valid"}, 137'(s_valid), 137'(1'b1));
      chk({tag, "_hold_key"}, 137'(key), 137'(fr.key));
    end
    info_ready = 1'b0;
    idle();
    chk({tag, "_valid_drop"}, 137'(s_valid), 137'(1'b0));
    chk({tag, "_busy_drop"}, 137'(s_busy), 137'(1'b0));
    chk({tag, "_key_kept"}, 137'(key), 137'(fr.key));
    chk({tag, "_valid_cycles"}, 137'(valid_cnt), 137'(d + 1));
  endtask

  initial begin
    vec_t   tbl[7];
    frame_t f1, f3, fr, last;
    int     n;
    logic   restart;
    int     d;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0};

    f1.key  = 128'h6c756b65696d796f7572666174686572;
    f1.addr = 8'hF0;
    f1.mode = 1'b1;
    f3.key  = f1.key;
    f3.addr = 8'h0F;
    f3.mode = 1'b0;

    n_rst       = 1'b0;
    frame_start = 1'b0;
    bit_strobe  = 1'b0;
    serial_in   = 1'b0;
    info_ready  = 1'b0;
    se_cnt      = 0;
    err_cnt     = 0;
    valid_cnt   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 137'(busy), 137'(1'b0));
    chk("reset_valid", 137'(info_valid), 137'(1'b0));
    chk("reset_err", 137'(frame_err), 137'(1'b0));
    chk("reset_fields", {key, address, mode}, 137'(0));
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Cycle-level vectors: idle strobe ignored, restart beats strobe, error pulse.
    for (int i = 0; i < 7; i++) begin
      info_ready = tbl[i].rdy;
      cyc(tbl[i].fs, tbl[i].bs, tbl[i].si);
      chk($sformatf("tbl%0d_se", i), 137'(s_se), 137'(tbl[i].se));
      chk($sformatf("tbl%0d_busy", i), 137'(s_busy), 137'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i), 137'(s_err), 137'(tbl[i].err));
      chk($sformatf("tbl%0d_valid", i), 137'(s_valid), 137'(tbl[i].valid));
    end
    info_ready = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal frame, immediate accept.
    run_frame(f1, 0, 1'b0, -1);
    chk("normal_shift_pulses", 137'(se_cnt), 137'(137));
    collect(f1, 0, "normal");
    chk("normal_no_err", 137'(err_cnt), 137'(0));

    // Backpressure for 20 cycles.
    run_frame(f1, 2, 1'b0, -1);
    collect(f1, 20, "backpressure");

    // Restart after 50 bits, then a full frame.
    start();
    repeat (50) strobe(1'b1);
    run_frame(f3, 0, 1'b0, -1);
    chk("restart_err_pulses", 137'(err_cnt), 137'(1));
    chk("restart_shift_pulses", 137'(se_cnt), 137'(137));
    collect(f3, 0, "restart");

    // Longest legal inter-strobe gap does not time out.
    run_frame(f1, 0, 1'b0, 70);
    chk("maxgap_no_err", 137'(err_cnt), 137'(0));
    collect(f1, 1, "maxgap");

    // Timeout after 60 bits: error lands TIMEOUT_CYC edges after the last strobe.
    err_cnt   = 0;
    valid_cnt = 0;
    start();
    repeat (60) strobe(1'b0);
    n = 0;
    do begin
      idle();
      n++;
    end while (!s_err && n < 400);
    chk("timeout_latency", 137'(n), 137'(TIMEOUT_CYC + 1));
    chk("timeout_busy", 137'(s_busy), 137'(1'b0));
    idle();
    chk("timeout_err_single", 137'(s_err), 137'(1'b0));
    chk("timeout_no_valid", 137'(valid_cnt), 137'(0));

    // Asynchronous reset at bit 100.
    start();
    repeat (100) strobe(1'b1);
    bit_strobe = 1'b1;
    serial_in  = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("midreset_se", 137'(shift_enable), 137'(1'b0));
    chk("midreset_busy", 137'(busy), 137'(1'b0));
    chk("midreset_valid_err", {info_valid, frame_err}, 137'(0));
    chk("midreset_fields", {key, address, mode}, 137'(0));
    bit_strobe = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(f3, 1, 1'b0, -1);
    collect(f3, 0, "after_reset");
    last = f3;

`ifdef PARITY_CHECK_EN
    // Flipped parity bit: error, no valid, fields untouched.
    run_frame(f1, 0, 1'b1, -1);
    idle();
    chk("parity_err", 137'(s_err), 137'(1'b1));
    chk("parity_busy", 137'(s_busy), 137'(1'b0));
    repeat (3) idle();
    chk("parity_no_valid", 137'(valid_cnt), 137'(0));
    chk("parity_err_single", 137'(err_cnt), 137'(1));
    chk("parity_key_kept", 137'(key), 137'(last.key));
`endif

    // Random frames, optional aborted prefix, random gaps and backpressure.
    for (int t = 0; t < 25; t++) begin
      fr.key  = {$urandom(), $urandom(), $urandom(), $urandom()};
      fr.addr = 8'($urandom());
      fr.mode = 1'($urandom());
      restart = ($urandom_range(3, 0) == 0);
      d       = int'($urandom_range(4, 0));
      if (restart) begin
        start();
        repeat ($urandom_range(136, 1)) strobe(1'($urandom()));
      end
      run_frame(fr, 3, 1'b0, -1);
      chk($sformatf("rand%0d_shift_pulses", t), 137'(se_cnt), 137'(137));
      chk($sformatf("rand%0d_err", t), 137'(err_cnt), 137'(restart));
      collect(fr, d, $sformatf("rand%0d", t));
      last = fr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
